// File: rtl/ft245_responder.sv
// ft245_responder: FT245-style asynchronous FIFO slave that bridges master rd#/wr# strobes to two byte streams.
// Latency: rxf#/txe# rise 3 cycles after a strobe falls at the pin; the RX head byte is loaded 1 cycle after the FIFO becomes non-empty.
// Backpressure: in_ready drops while the RX FIFO is full; txe# stays high while the TX FIFO is full; TX bytes leave on out_valid & out_ready.
module ft245_responder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP        = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  inout  wire  [7:0] usb_data,
  output logic       usb_rxf,
  output logic       usb_txe,
  input  logic       usb_rd,
  input  logic       usb_wr,
  input  logic       usb_siwua,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err_rd,
  output logic       err_wr
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam int         PW       = DEPTH_LOG2 + 1;
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  typedef enum logic [1:0] {R_EMPTY, R_READY, R_BUSY, R_GAP} rx_state_t;
  typedef enum logic [1:0] {T_READY, T_FULL, T_BUSY, T_GAP} tx_state_t;

  logic       r_rd_s1, r_rd_s2, r_rd_s3;
  logic       r_wr_s1, r_wr_s2, r_wr_s3;
  logic       r_rd_arm, r_wr_arm, r_live;
  logic [7:0] r_dat_d1, r_dat_d2;

  logic [7:0]    r_rx_mem [DEPTH];
  logic [PW-1:0] r_rx_wp, r_rx_rp;
  logic [7:0]    r_tx_mem [DEPTH];
  logic [PW-1:0] r_tx_wp, r_tx_rp;

  rx_state_t  r_rx_st;
  tx_state_t  r_tx_st;
  logic [3:0] r_rx_gap, r_tx_gap;
  logic [7:0] r_rx_dat;
  logic       r_rxf, r_txe, r_err_rd, r_err_wr;

  logic w_rd_fall, w_rd_rise, w_wr_fall, w_wr_rise;
  logic w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
  logic w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic w_oe;
  logic w_unused;

  assign w_unused = usb_siwua;

  // A strobe still low when reset releases must not look like a fresh fall:
  // edges only count once a genuine high pin sample has been seen (arm).
  assign w_rd_fall = r_rd_arm & r_rd_s3 & ~r_rd_s2;
  assign w_rd_rise = ~r_rd_s3 & r_rd_s2;
  assign w_wr_fall = r_wr_arm & r_wr_s3 & ~r_wr_s2;
  assign w_wr_rise = ~r_wr_s3 & r_wr_s2;

  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[DEPTH_LOG2] != r_rx_rp[DEPTH_LOG2]) &&
                      (r_rx_wp[DEPTH_LOG2-1:0] == r_rx_rp[DEPTH_LOG2-1:0]);
  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[DEPTH_LOG2] != r_tx_rp[DEPTH_LOG2]) &&
                      (r_tx_wp[DEPTH_LOG2-1:0] == r_tx_rp[DEPTH_LOG2-1:0]);

  assign in_ready  = reset_n & ~w_rx_full;
  assign w_rx_push = in_valid & in_ready;
  assign w_rx_pop  = (r_rx_st == R_BUSY) & w_rd_rise;

  assign out_valid = ~w_tx_empty;
  assign out_data  = r_tx_mem[r_tx_rp[DEPTH_LOG2-1:0]];
  assign w_tx_pop  = out_valid & out_ready;
  assign w_tx_push = (r_tx_st == T_READY) & w_wr_fall;

  // The bus follows the raw rd# pin so the master sees data without synchronizer delay.
  assign w_oe     = reset_n & ~usb_rd & ((r_rx_st == R_READY) || (r_rx_st == R_BUSY));
  assign usb_data = w_oe ? r_rx_dat : 8'hzz;

  assign usb_rxf = r_rxf;
  assign usb_txe = r_txe;
  assign err_rd  = r_err_rd;
  assign err_wr  = r_err_wr;

  // Strobe synchronizers plus a data delay line kept in step with the wr# stages.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rd_s1  <= 1'b1; r_rd_s2 <= 1'b1; r_rd_s3 <= 1'b1;
      r_wr_s1  <= 1'b1; r_wr_s2 <= 1'b1; r_wr_s3 <= 1'b1;
      r_rd_arm <= 1'b0; r_wr_arm <= 1'b0; r_live <= 1'b0;
      r_dat_d1 <= 8'h00; r_dat_d2 <= 8'h00;
    end else begin
      r_rd_s1  <= usb_rd;  r_rd_s2 <= r_rd_s1; r_rd_s3 <= r_rd_s2;
      r_wr_s1  <= usb_wr;  r_wr_s2 <= r_wr_s1; r_wr_s3 <= r_wr_s2;
      r_live   <= 1'b1;
      r_rd_arm <= r_rd_arm | (r_live & r_rd_s1);
      r_wr_arm <= r_wr_arm | (r_live & r_wr_s1);
      r_dat_d1 <= usb_data;
      r_dat_d2 <= r_dat_d1;
    end
  end

  // FIFO storage writes; contents are don't-care while the pointers say empty.
  always_ff @(posedge clock) begin
    if (w_rx_push) r_rx_mem[r_rx_wp[DEPTH_LOG2-1:0]] <= in_data;
    if (w_tx_push) r_tx_mem[r_tx_wp[DEPTH_LOG2-1:0]] <= r_dat_d2;
  end

  // FIFO pointers; push and pop advance independently so both can happen in one cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rx_wp <= '0; r_rx_rp <= '0;
      r_tx_wp <= '0; r_tx_rp <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + PW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + PW'(1);
      if (w_tx_push) r_tx_wp <= r_tx_wp + PW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + PW'(1);
    end
  end

  // RX FSM: present the head byte, pop it when the master's read strobe completes.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rx_st  <= R_EMPTY;
      r_rxf    <= 1'b1;
      r_rx_dat <= 8'h00;
      r_rx_gap <= 4'd0;
      r_err_rd <= 1'b0;
    end else begin
      r_err_rd <= 1'b0;
      case (r_rx_st)
        R_EMPTY: begin
          if (w_rd_fall) r_err_rd <= 1'b1;
          if (!w_rx_empty) begin
            r_rx_dat <= r_rx_mem[r_rx_rp[DEPTH_LOG2-1:0]];
            r_rx_st  <= R_READY;
            r_rxf    <= 1'b0;
          end
        end
        R_READY: begin
          if (w_rd_fall) begin
            r_rx_st <= R_BUSY;
            r_rxf   <= 1'b1;
          end
        end
        R_BUSY: begin
          if (w_rd_rise) begin
            r_rx_st  <= R_GAP;
            r_rx_gap <= GAP_LAST;
          end
        end
        default: begin
          if (w_rd_fall) r_err_rd <= 1'b1;
          if (r_rx_gap == 4'd0) r_rx_st <= R_EMPTY;
          else                  r_rx_gap <= r_rx_gap - 4'd1;
        end
      endcase
    end
  end

  // TX FSM: accept one byte per wr# strobe, hold txe# high while busy, in gap or full.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_tx_st  <= T_READY;
      r_txe    <= 1'b0;
      r_tx_gap <= 4'd0;
      r_err_wr <= 1'b0;
    end else begin
      r_err_wr <= 1'b0;
      case (r_tx_st)
        T_READY: begin
          if (w_wr_fall) begin
            r_tx_st <= T_BUSY;
            r_txe   <= 1'b1;
          end
        end
        T_BUSY: begin
          if (w_wr_fall) r_err_wr <= 1'b1;
          if (w_wr_rise) begin
            r_tx_st  <= T_GAP;
            r_tx_gap <= GAP_LAST;
          end
        end
        T_GAP: begin
          if (w_wr_fall) r_err_wr <= 1'b1;
          if (r_tx_gap == 4'd0) begin
            r_tx_st <= w_tx_full ? T_FULL : T_READY;
            r_txe   <= w_tx_full;
          end else begin
            r_tx_gap <= r_tx_gap - 4'd1;
          end
        end
        default: begin
          if (w_wr_fall) r_err_wr <= 1'b1;
          if (!w_tx_full) begin
            r_tx_st <= T_READY;
            r_txe   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
